// File: rtl/fpnormround_if.sv
`timescale 1ns/1ps
// Handshake/bus bundle between the FP adder and the normalize/round stage.
// out_flags exists only when FPNORMROUND_FLAGS_EN is defined.
interface fpnormround_if #(
  parameter int LOG_BIT = 5,
  parameter int EXP_BIT = 8
);
  localparam int N_BIT    = 1 << LOG_BIT;
  localparam int MAN_BIT  = N_BIT - EXP_BIT - 1;
  localparam int WIDE_BIT = 2 * MAN_BIT + 4;

  logic                in_valid;
  logic                in_ready;
  logic                in_sign;
  logic [EXP_BIT-1:0]  in_exp;
  logic [WIDE_BIT-1:0] in_man;
  logic                in_special;
  logic [N_BIT-1:0]    in_special_val;
  logic                out_valid;
  logic                out_ready;
  logic [N_BIT-1:0]    out_data;
`ifdef FPNORMROUND_FLAGS_EN
  logic [2:0]          out_flags;

  modport master (
    output in_valid, input in_ready, output in_sign, output in_exp, output in_man,
    output in_special, output in_special_val,
    input out_valid, output out_ready, input out_data, input out_flags
  );
  modport slave (
    input in_valid, output in_ready, input in_sign, input in_exp, input in_man,
    input in_special, input in_special_val,
    output out_valid, input out_ready, output out_data, output out_flags
  );
`else
  modport master (
    output in_valid, input in_ready, output in_sign, output in_exp, output in_man,
    output in_special, output in_special_val,
    input out_valid, output out_ready, input out_data
  );
  modport slave (
    input in_valid, output in_ready, input in_sign, input in_exp, input in_man,
    input in_special, input in_special_val,
    output out_valid, input out_ready, output out_data
  );
`endif
endinterface

// File: rtl/fpnormround.sv
`timescale 1ns/1ps
// Normalize + round-to-nearest-even after FP add/sub; 3-cycle latency, full throughput, all stages hold
// while the output is stalled (in_ready = !out_valid || out_ready). FPNORMROUND_FLAGS_EN adds out_flags.
module fpnormround #(
  parameter int LOG_BIT = 5,
  parameter int EXP_BIT = 8
) (
  input logic          clk,
  input logic          rst,
  fpnormround_if.slave bus
);
  localparam int N_BIT    = 1 << LOG_BIT;
  localparam int MAN_BIT  = N_BIT - EXP_BIT - 1;
  localparam int WIDE_BIT = 2 * MAN_BIT + 4;
  localparam int HID      = WIDE_BIT - 3;
  localparam int EW       = EXP_BIT + 2;
  localparam int LZW      = $clog2(HID + 2);
  localparam int SW       = EW + MAN_BIT;
  localparam logic signed [EW-1:0] EXP_SAT = EW'((1 << EXP_BIT) - 1);

  function automatic logic [LZW-1:0] lzc_f(input logic [HID:0] v);
    lzc_f = LZW'(HID + 1);
    for (int i = 0; i <= HID; i++) begin
      if (v[i]) lzc_f = LZW'(HID - i);
    end
  endfunction

  logic adv;

  logic                   s1_vld_q, s2_vld_q, s3_vld_q;
  logic                   s1_sign_q, s1_c2_q, s1_c1_q, s1_zero_q, s1_spc_q;
  logic signed [EW-1:0]   s1_exp_q, s1_exp_d;
  logic [WIDE_BIT-1:0]    s1_man_q;
  logic [LZW-1:0]         s1_lzc_q, s1_lzc_d;
  logic [N_BIT-1:0]       s1_sval_q;

  logic                   s2_sign_q, s2_zero_q, s2_spc_q;
  logic signed [EW-1:0]   s2_exp_q, s2_exp_d;
  logic [HID:0]           s2_man_q, s2_man_d;
  logic [N_BIT-1:0]       s2_sval_q;
  logic signed [EW-1:0]   lim, lzc_ext, sh_amt;

  logic [MAN_BIT-1:0]     frac;
  logic                   rnd_g, rnd_s, rnd_l, rnd_up, ovf;
  logic signed [EW-1:0]   field, rexp;
  logic [SW-1:0]          rsum;
  logic [N_BIT-1:0]       out_data_q, out_data_d;

  assign adv           = !s3_vld_q || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = s3_vld_q;
  assign bus.out_data  = out_data_q;

  always_comb begin
    s1_exp_d = (bus.in_exp == '0) ? EW'(1) : signed'({{(EW-EXP_BIT){1'b0}}, bus.in_exp});
    s1_lzc_d = lzc_f(bus.in_man[HID:0]);
  end

  // Right shifts fold the dropped bits into bit 0 so rounding still sees them as sticky.
  always_comb begin
    lim      = s1_exp_q - EW'(1);
    lzc_ext  = signed'({{(EW-LZW){1'b0}}, s1_lzc_q});
    sh_amt   = (lzc_ext <= lim) ? lzc_ext : lim;
    s2_exp_d = s1_exp_q;
    s2_man_d = s1_man_q[HID:0];
    if (s1_c2_q) begin
      s2_man_d    = s1_man_q[WIDE_BIT-1:2];
      s2_man_d[0] = |s1_man_q[2:0];
      s2_exp_d    = s1_exp_q + EW'(2);
    end else if (s1_c1_q) begin
      s2_man_d    = s1_man_q[WIDE_BIT-2:1];
      s2_man_d[0] = |s1_man_q[1:0];
      s2_exp_d    = s1_exp_q + EW'(1);
    end else begin
      s2_man_d = s1_man_q[HID:0] << sh_amt;
      s2_exp_d = s1_exp_q - sh_amt;
    end
  end

  // Rounding adds into {field, fraction} so a fraction carry bumps the exponent (incl. denormal -> min normal).
  always_comb begin
    frac       = s2_man_q[2*MAN_BIT:MAN_BIT+1];
    rnd_g      = s2_man_q[MAN_BIT];
    rnd_s      = |s2_man_q[MAN_BIT-1:0];
    rnd_l      = s2_man_q[MAN_BIT+1];
    rnd_up     = rnd_g && (rnd_s || rnd_l);
    field      = s2_man_q[HID] ? s2_exp_q : '0;
    rsum       = {field, frac} + SW'(rnd_up);
    rexp       = signed'(rsum[SW-1:MAN_BIT]);
    ovf        = (rexp >= EXP_SAT);
    out_data_d = {s2_sign_q, rexp[EXP_BIT-1:0], rsum[MAN_BIT-1:0]};
    if (s2_spc_q) begin
      out_data_d = s2_sval_q;
    end else if (s2_zero_q) begin
      out_data_d = {s2_sign_q, {(N_BIT-1){1'b0}}};
    end else if (ovf) begin
      out_data_d = {s2_sign_q, {EXP_BIT{1'b1}}, {MAN_BIT{1'b0}}};
    end
  end

`ifdef FPNORMROUND_FLAGS_EN
  logic [2:0] flags_q, flags_d;
  logic       inexact;

  always_comb begin
    inexact = rnd_g || rnd_s;
    flags_d = {ovf, (rexp == '0) && inexact, inexact};
    if (s2_spc_q || s2_zero_q) flags_d = '0;
  end

  assign bus.out_flags = flags_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      s3_vld_q   <= 1'b0;
      out_data_q <= '0;
`ifdef FPNORMROUND_FLAGS_EN
      flags_q    <= '0;
`endif
    end else if (adv) begin
      s1_vld_q   <= bus.in_valid;
      s2_vld_q   <= s1_vld_q;
      s3_vld_q   <= s2_vld_q;
      out_data_q <= out_data_d;
`ifdef FPNORMROUND_FLAGS_EN
      flags_q    <= flags_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign_q <= bus.in_sign;
      s1_exp_q  <= s1_exp_d;
      s1_man_q  <= bus.in_man;
      s1_lzc_q  <= s1_lzc_d;
      s1_c2_q   <= bus.in_man[WIDE_BIT-1];
      s1_c1_q   <= bus.in_man[WIDE_BIT-2];
      s1_zero_q <= (bus.in_man == '0);
      s1_spc_q  <= bus.in_special;
      s1_sval_q <= bus.in_special_val;
      s2_sign_q <= s1_sign_q;
      s2_exp_q  <= s2_exp_d;
      s2_man_q  <= s2_man_d;
      s2_zero_q <= s1_zero_q;
      s2_spc_q  <= s1_spc_q;
      s2_sval_q <= s1_sval_q;
    end
  end
endmodule

// File: tb/tb_fpnormround.sv
`timescale 1ns/1ps
// Bench for fpnormround: exact-arithmetic rounding model, scoreboard compare, directed vectors.
module tb_fpnormround;
  typedef struct {
    logic        sgn;
    logic [7:0]  ex;
    logic [49:0] man;
    logic        sp;
    logic [31:0] sv;
    logic [31:0] ed;
    logic [2:0]  ef;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  f;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpnormround_if #(.LOG_BIT(5), .EXP_BIT(8)) bus();
  fpnormround #(.LOG_BIT(5), .EXP_BIT(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   n_out = 0;
  bit   lat_chk = 1'b0;
  exp_t sbq[$];
  vec_t vecs[15];

  always @(posedge clk) cyc <= cyc + 1;

  // Round man * 2^(E-174) to the binary32 grid with exact integer arithmetic.
  function automatic void model(input logic sgn, input logic [7:0] ex, input logic [49:0] man,
                                input logic sp, input logic [31:0] sv,
                                output logic [31:0] d, output logic [2:0] f);
    int E, p, e, u, k, s, field;
    logic [127:0] q, rem, half, fr;
    logic inx, ovf;
    d = '0; f = '0;
    if (sp) begin d = sv; return; end
    if (man == '0) begin d = {sgn, 31'b0}; return; end
    E = (ex == 0) ? 1 : int'(ex);
    p = 0;
    for (int i = 0; i < 50; i++) if (man[i]) p = i;
    e = p + E - 174;
    u = (e >= -126) ? e - 23 : -149;
    k = E - 174 - u;
    inx = 1'b0;
    if (k >= 0) begin
      q = 128'(man) << k;
    end else begin
      s    = -k;
      q    = 128'(man) >> s;
      rem  = 128'(man) & ((128'(1) << s) - 128'(1));
      half = 128'(1) << (s - 1);
      inx  = (rem != 0);
      if (rem > half || (rem == half && q[0])) q = q + 128'(1);
    end
    if (q >= (128'(1) << 24)) begin q = q >> 1; u = u + 1; end
    if (q >= (128'(1) << 23)) begin field = u + 150; fr = q - (128'(1) << 23); end
    else begin field = 0; fr = q; end
    ovf = (field >= 255);
    if (ovf) d = {sgn, 8'hFF, 23'b0};
    else     d = {sgn, 8'(field), fr[22:0]};
    f = {ovf, (field == 0) && inx, inx};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [31:0] md;
    logic [2:0]  mf;
    if (rst) begin
      sbq.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (sbq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_out: got %h required no output", bus.out_data);
        end else begin
          e = sbq.pop_front();
          chk("out_data", bus.out_data, e.d);
`ifdef FPNORMROUND_FLAGS_EN
          chk("out_flags", 32'(bus.out_flags), 32'(e.f));
`endif
          if (lat_chk) chk("latency", 32'(cyc - e.acc), 32'd3);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        model(bus.in_sign, bus.in_exp, bus.in_man, bus.in_special, bus.in_special_val, md, mf);
        e.d = md; e.f = mf; e.acc = cyc;
        sbq.push_back(e);
      end
    end
  end

  task automatic drive(input vec_t v);
    bus.in_valid       = 1'b1;
    bus.in_sign        = v.sgn;
    bus.in_exp         = v.ex;
    bus.in_man         = v.man;
    bus.in_special     = v.sp;
    bus.in_special_val = v.sv;
  endtask

  task automatic send(input vec_t v);
    bit got, done;
    done = 1'b0;
    drive(v);
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      got = bus.in_ready;
      @(posedge clk); #1;
      done = got;
    end
    if (!done) begin n_vec++; n_err++; $display("FAIL send_timeout: got no accept required accept"); end
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && sbq.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain_pending", 32'(sbq.size()), 32'd0);
  endtask

  function automatic vec_t mk(input logic sgn, input logic [7:0] ex, input logic [49:0] man,
                              input logic [31:0] ed, input logic [2:0] ef);
    vec_t v;
    v.sgn = sgn; v.ex = ex; v.man = man; v.sp = 1'b0; v.sv = '0; v.ed = ed; v.ef = ef;
    return v;
  endfunction

  initial begin
    logic [31:0] md;
    logic [2:0]  mf;
    logic [63:0] r;
    vec_t bp[5];
    int   acc, b, out0;
    bit   got;

    vecs[0]  = mk(0, 127, 50'd1 << 47,                                 32'h3F800000, 3'b000);
    vecs[1]  = mk(0, 127, 50'd3 << 47,                                 32'h40400000, 3'b000);
    vecs[2]  = mk(0, 130, 50'd1 << 40,                                 32'h3D800000, 3'b000);
    vecs[3]  = mk(0, 127, (50'd1 << 47) | (50'd1 << 23),               32'h3F800000, 3'b001);
    vecs[4]  = mk(0, 127, (50'd1 << 47) | (50'd1 << 24) | (50'd1 << 23), 32'h3F800002, 3'b001);
    vecs[5]  = mk(0, 127, (50'd1 << 47) | (50'd1 << 23) | 50'd1,       32'h3F800001, 3'b001);
    vecs[6]  = mk(0, 254, 50'd1 << 48,                                 32'h7F800000, 3'b100);
    vecs[7]  = mk(0, 1,   50'd1 << 46,                                 32'h00400000, 3'b000);
    vecs[8]  = mk(1, 127, 50'd0,                                       32'h80000000, 3'b000);
    r = {$urandom(), $urandom()};
    vecs[9]  = mk(0, 8'd3, r[49:0],                                    32'h7FC00000, 3'b000);
    vecs[9].sp = 1'b1; vecs[9].sv = 32'h7FC00000;
    vecs[10] = mk(0, 127, (50'd1 << 49) | 50'd1,                       32'h40800000, 3'b001);
    vecs[11] = mk(0, 1,   50'h7FFFFF800000,                            32'h00800000, 3'b001);
    vecs[12] = mk(0, 0,   50'd1 << 47,                                 32'h00800000, 3'b000);
    vecs[13] = mk(0, 254, 50'hFFFFFF800000,                            32'h7F800000, 3'b101);
    vecs[14] = mk(1, 100, 50'd5 << 45,                                 32'hB2200000, 3'b000);

    bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_exp = '0; bus.in_man = '0;
    bus.in_special = 1'b0; bus.in_special_val = '0; bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef FPNORMROUND_FLAGS_EN
    chk("rst_out_flags", 32'(bus.out_flags), 32'd0);
`endif
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      model(vecs[i].sgn, vecs[i].ex, vecs[i].man, vecs[i].sp, vecs[i].sv, md, mf);
      chk($sformatf("model_pin_%0d", i), md, vecs[i].ed);
`ifdef FPNORMROUND_FLAGS_EN
      chk($sformatf("model_flags_%0d", i), 32'(mf), 32'(vecs[i].ef));
`endif
    end

    // Directed vectors back-to-back with out_ready held high.
    lat_chk = 1'b1;
    for (int i = 0; i < 15; i++) send(vecs[i]);
    bus.in_valid = 1'b0;
    drain();

    // Backpressure: out_ready low for 6 cycles while 5 beats are offered.
    lat_chk = 1'b0;
    for (int i = 0; i < 5; i++) bp[i] = mk(i[0], 8'(120 + i), (50'd1 << 47) | 50'(i << 30), 32'h0, 3'b0);
    out0 = n_out;
    bus.out_ready = 1'b0;
    acc = 0; b = 0;
    drive(bp[0]);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      got = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (got) begin
        acc++; b++;
        if (b < 5) drive(bp[b]); else bus.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("bp_accepted", 32'(acc), 32'd3);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 30 && b < 5; k++) begin
      @(negedge clk);
      got = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (got) begin
        b++;
        if (b < 5) drive(bp[b]); else bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    chk("bp_all_sent", 32'(b), 32'd5);
    drain();
    chk("bp_delivered", 32'(n_out - out0), 32'd5);

    // Reset mid-stream: in-flight beats must vanish.
    lat_chk = 1'b1;
    send(vecs[0]); send(vecs[1]); send(vecs[2]);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out0 = n_out;
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_data", bus.out_data, 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_no_output", 32'(n_out - out0), 32'd0);

    send(vecs[14]);
    bus.in_valid = 1'b0;
    drain();
    chk("final_delivered", 32'(n_out - out0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
